pc_sequencer: RTL and testbench

- Parametrised program-counter unit for the MIPS pipeline fetch stage.
- Selects among sequential, branch, jump and jump-register next-PC sources and holds the PC register.
- Supports stall with a pending-redirect latch, a start/halt state machine and a retired-fetch counter.
- An optional trap vector can be compiled in.

---
 rtl/pc_sequencer.sv | 146 ++++++++++++++
 tb/tb_pc_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with IDLE/RUN/HALT control,
// stall-time pending-redirect latch and a retired-fetch counter.
// Optional trap vector compiled in with `define PC_TRAP_EN.
module pc_sequencer #(
   parameter int unsigned         NBITS       = 32,
   parameter logic [NBITS-1:0]    RESET_PC    = '0,
   parameter logic [NBITS-1:0]    TRAP_VECTOR = NBITS'(32'h0000_0080),
   parameter int unsigned         CNT_BITS    = 32
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_Start,
   input  logic                i_Halt,
   input  logic                i_Stall,
   input  logic [1:0]          i_PCSrc,
   input  logic [NBITS-1:0]    i_SumadorBranch,
   input  logic [NBITS-1:0]    i_JumpAddr,
   input  logic [NBITS-1:0]    i_JumpReg,
`ifdef PC_TRAP_EN
   input  logic                i_Trap,
`endif
   output logic [NBITS-1:0]    o_PC,
   output logic [NBITS-1:0]    o_PC4,
   output logic                o_Flush,
   output logic                o_Running,
   output logic [CNT_BITS-1:0] o_FetchCount
);

   localparam logic [1:0] SRC_SEQ = 2'b00;
   localparam logic [1:0] SRC_BR  = 2'b01;
   localparam logic [1:0] SRC_JMP = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_HALT = 2'b10
   } state_t;

   state_t                state_q, state_d;
   logic [NBITS-1:0]      pc_q, pc_d;
   logic                  pend_valid_q, pend_valid_d;
   logic [NBITS-1:0]      pend_addr_q, pend_addr_d;
   logic [CNT_BITS-1:0]   cnt_q, cnt_d;
   logic                  flush_q, flush_d;

   logic                  trap_c;
   logic                  redirect_c;
   logic [NBITS-1:0]      target_c;
   logic [NBITS-1:0]      pc4_c;

   // Trap request is tied off when the trap feature is not built
`ifdef PC_TRAP_EN
   assign trap_c = i_Trap;
`else
   assign trap_c = 1'b0;
`endif

   assign redirect_c = (i_PCSrc != SRC_SEQ);
   assign pc4_c      = pc_q + NBITS'(4);

   // Redirect target selection from the PC source code
   always_comb begin
      target_c = i_JumpReg;
      case (i_PCSrc)
         SRC_BR:  target_c = i_SumadorBranch;
         SRC_JMP: target_c = i_JumpAddr;
         default: target_c = i_JumpReg;
      endcase
   end

   // Next-state, next-PC, pending latch and counter update
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pend_valid_d = pend_valid_q;
      pend_addr_d  = pend_addr_q;
      cnt_d        = cnt_q;
      flush_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_Start) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (trap_c) begin
               // Trap wins over stall and halt; a concurrent halt still stops after it
               pc_d         = TRAP_VECTOR;
               flush_d      = 1'b1;
               pend_valid_d = 1'b0;
               cnt_d        = cnt_q + CNT_BITS'(1);
               if (i_Halt) state_d = ST_HALT;
            end else if (i_Halt) begin
               state_d = ST_HALT;
            end else if (i_Stall) begin
               if (redirect_c) begin
                  pend_valid_d = 1'b1;
                  pend_addr_d  = target_c;
               end
            end else if (pend_valid_q) begin
               pc_d         = pend_addr_q;
               flush_d      = 1'b1;
               pend_valid_d = 1'b0;
               cnt_d        = cnt_q + CNT_BITS'(1);
            end else if (redirect_c) begin
               pc_d    = target_c;
               flush_d = 1'b1;
               cnt_d   = cnt_q + CNT_BITS'(1);
            end else begin
               pc_d  = pc4_c;
               cnt_d = cnt_q + CNT_BITS'(1);
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q      <= ST_IDLE;
         pc_q         <= RESET_PC;
         pend_valid_q <= 1'b0;
         pend_addr_q  <= '0;
         cnt_q        <= '0;
         flush_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pend_valid_q <= pend_valid_d;
         pend_addr_q  <= pend_addr_d;
         cnt_q        <= cnt_d;
         flush_q      <= flush_d;
      end
   end

   assign o_PC         = pc_q;
   assign o_PC4        = pc4_c;
   assign o_Flush      = flush_q;
   assign o_Running    = (state_q == ST_RUN);
   assign o_FetchCount = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: vector table through a scoreboard queue plus
// hand-written reset-mid-stall, wrap-around and (with PC_TRAP_EN) trap sequences.
module tb_pc_sequencer;

   typedef struct {
      logic        start, halt, stall, trap;
      logic [1:0]  src;
      logic [31:0] br, jmp, jr;
      logic [31:0] e_pc;
      logic        e_flush, e_run;
      logic [31:0] e_cnt;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start, halt, stall, trap;
   logic [1:0]  src;
   logic [31:0] br, jmp, jr;
   logic [31:0] pc, pc4, cnt;
   logic        flush, run;

   logic        start2;
   logic [31:0] pc_w, pc4_w, cnt_w;
   logic        flush_w, run_w;

   int n_cmp = 0;
   int n_bad = 0;
   vec_t exp_q[$];

   always #5 clk = ~clk;

   pc_sequencer #(.NBITS(32), .RESET_PC(32'h0), .CNT_BITS(32)) dut (
      .i_clk(clk), .i_reset(rst_n), .i_Start(start), .i_Halt(halt), .i_Stall(stall),
      .i_PCSrc(src), .i_SumadorBranch(br), .i_JumpAddr(jmp), .i_JumpReg(jr),
`ifdef PC_TRAP_EN
      .i_Trap(trap),
`endif
      .o_PC(pc), .o_PC4(pc4), .o_Flush(flush), .o_Running(run), .o_FetchCount(cnt)
   );

   pc_sequencer #(.NBITS(32), .RESET_PC(32'hFFFF_FFF8), .CNT_BITS(32)) dut_wrap (
      .i_clk(clk), .i_reset(rst_n), .i_Start(start2), .i_Halt(1'b0), .i_Stall(1'b0),
      .i_PCSrc(2'b00), .i_SumadorBranch(32'h0), .i_JumpAddr(32'h0), .i_JumpReg(32'h0),
`ifdef PC_TRAP_EN
      .i_Trap(1'b0),
`endif
      .o_PC(pc_w), .o_PC4(pc4_w), .o_Flush(flush_w), .o_Running(run_w), .o_FetchCount(cnt_w)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic st, input logic ha, input logic sl,
                               input logic [1:0] s, input logic [31:0] tgt,
                               input logic [31:0] epc, input logic efl,
                               input logic eru, input logic [31:0] ecnt);
      vec_t v;
      v.start = st; v.halt = ha; v.stall = sl; v.trap = 1'b0; v.src = s;
      v.br  = 32'hBAD0_0010;
      v.jmp = 32'hBAD0_0020;
      v.jr  = 32'hBAD0_0030;
      case (s)
         2'b01:   v.br  = tgt;
         2'b10:   v.jmp = tgt;
         2'b11:   v.jr  = tgt;
         default: ;
      endcase
      v.e_pc = epc; v.e_flush = efl; v.e_run = eru; v.e_cnt = ecnt;
      return v;
   endfunction

   task automatic idle_inputs();
      start = 0; halt = 0; stall = 0; trap = 0; src = 2'b00;
      br = 0; jmp = 0; jr = 0; start2 = 0;
   endtask

   // Drive one record, queue its expectation, compare after the edge
   task automatic step(input vec_t v, input string tag);
      vec_t e;
      start = v.start; halt = v.halt; stall = v.stall; trap = v.trap; src = v.src;
      br = v.br; jmp = v.jmp; jr = v.jr;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check({tag, " pc"},    pc,          e.e_pc);
      check({tag, " pc4"},   pc4,         e.e_pc + 32'd4);
      check({tag, " flush"}, 32'(flush),  32'(e.e_flush));
      check({tag, " run"},   32'(run),    32'(e.e_run));
      check({tag, " cnt"},   cnt,         e.e_cnt);
   endtask

   task automatic do_reset();
      idle_inputs();
      #2 rst_n = 0;
      #3 rst_n = 1;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t vecs[21];
      vec_t t;
      logic [31:0] wrap_exp[3];

      idle_inputs();
      #12 rst_n = 1;
      @(negedge clk);
      check("reset pc",    pc,         32'h0);
      check("reset pc4",   pc4,        32'h4);
      check("reset flush", 32'(flush), 32'h0);
      check("reset run",   32'(run),   32'h0);
      check("reset cnt",   cnt,        32'h0);
      check("reset wrap pc", pc_w,     32'hFFFF_FFF8);

      //               st ha sl src   tgt        pc         fl ru cnt
      vecs[0]  = mk(1, 0, 0, 2'b00, 32'h0,     32'h0,     0, 1, 0);
      vecs[1]  = mk(0, 0, 0, 2'b00, 32'h0,     32'h4,     0, 1, 1);
      vecs[2]  = mk(0, 0, 0, 2'b00, 32'h0,     32'h8,     0, 1, 2);
      vecs[3]  = mk(0, 0, 0, 2'b00, 32'h0,     32'hC,     0, 1, 3);
      vecs[4]  = mk(0, 0, 0, 2'b00, 32'h0,     32'h10,    0, 1, 4);
      vecs[5]  = mk(0, 0, 0, 2'b01, 32'h40,    32'h40,    1, 1, 5);
      vecs[6]  = mk(0, 0, 0, 2'b00, 32'h0,     32'h44,    0, 1, 6);
      vecs[7]  = mk(0, 0, 0, 2'b10, 32'h1000,  32'h1000,  1, 1, 7);
      vecs[8]  = mk(0, 0, 0, 2'b11, 32'h20,    32'h20,    1, 1, 8);
      vecs[9]  = mk(0, 0, 1, 2'b00, 32'h0,     32'h20,    0, 1, 8);
      vecs[10] = mk(0, 0, 1, 2'b10, 32'h100,   32'h20,    0, 1, 8);
      vecs[11] = mk(0, 0, 1, 2'b00, 32'h0,     32'h20,    0, 1, 8);
      vecs[12] = mk(0, 0, 0, 2'b01, 32'h500,   32'h100,   1, 1, 9);
      vecs[13] = mk(0, 0, 0, 2'b00, 32'h0,     32'h104,   0, 1, 10);
      vecs[14] = mk(0, 0, 1, 2'b01, 32'h200,   32'h104,   0, 1, 10);
      vecs[15] = mk(0, 0, 1, 2'b11, 32'h300,   32'h104,   0, 1, 10);
      vecs[16] = mk(0, 0, 0, 2'b00, 32'h0,     32'h300,   1, 1, 11);
      vecs[17] = mk(1, 0, 0, 2'b00, 32'h0,     32'h304,   0, 1, 12);
      vecs[18] = mk(0, 1, 0, 2'b10, 32'h900,   32'h304,   0, 0, 12);
      vecs[19] = mk(1, 0, 0, 2'b00, 32'h0,     32'h304,   0, 0, 12);
      vecs[20] = mk(0, 0, 0, 2'b01, 32'h40,    32'h304,   0, 0, 12);
      for (int i = 0; i < 21; i++) step(vecs[i], $sformatf("vec%0d", i));

      // Reset while stalled with a pending jump: the jump must be forgotten
      do_reset();
      step(mk(1, 0, 0, 2'b00, 32'h0,   32'h0, 0, 1, 0), "mid0");
      step(mk(0, 0, 0, 2'b00, 32'h0,   32'h4, 0, 1, 1), "mid1");
      step(mk(0, 0, 0, 2'b00, 32'h0,   32'h8, 0, 1, 2), "mid2");
      step(mk(0, 0, 1, 2'b10, 32'h700, 32'h8, 0, 1, 2), "mid3");
      #2 rst_n = 0;
      #1;
      check("midrst pc",    pc,         32'h0);
      check("midrst run",   32'(run),   32'h0);
      check("midrst cnt",   cnt,        32'h0);
      check("midrst flush", 32'(flush), 32'h0);
      idle_inputs();
      #2 rst_n = 1;
      step(mk(1, 0, 0, 2'b00, 32'h0, 32'h0, 0, 1, 0), "after0");
      step(mk(0, 0, 0, 2'b00, 32'h0, 32'h4, 0, 1, 1), "after1");
      step(mk(0, 0, 0, 2'b00, 32'h0, 32'h8, 0, 1, 2), "after2");

      // PC+4 wrap from a near-top reset vector
      do_reset();
      check("wrap reset pc4", pc4_w, 32'hFFFF_FFFC);
      start2 = 1;
      @(posedge clk); #1;
      start2 = 0;
      check("wrap start pc", pc_w, 32'hFFFF_FFF8);
      check("wrap start run", 32'(run_w), 32'h1);
      wrap_exp[0] = 32'hFFFF_FFFC;
      wrap_exp[1] = 32'h0000_0000;
      wrap_exp[2] = 32'h0000_0004;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check($sformatf("wrap pc%0d", i),  pc_w,  wrap_exp[i]);
         check($sformatf("wrap pc4_%0d", i), pc4_w, wrap_exp[i] + 32'd4);
         check($sformatf("wrap flush%0d", i), 32'(flush_w), 32'h0);
      end
      check("wrap cnt", cnt_w, 32'd3);

`ifdef PC_TRAP_EN
      // Trap beats stall, then halt freezes the PC for good
      do_reset();
      step(mk(1, 0, 0, 2'b00, 32'h0,  32'h0,  0, 1, 0), "trap0");
      step(mk(0, 0, 0, 2'b10, 32'h30, 32'h30, 1, 1, 1), "trap1");
      t = mk(0, 0, 1, 2'b00, 32'h0, 32'h80, 1, 1, 2); t.trap = 1;
      step(t, "trap2");
      step(mk(0, 0, 0, 2'b00, 32'h0,  32'h84, 0, 1, 3), "trap3");
      step(mk(0, 1, 0, 2'b00, 32'h0,  32'h84, 0, 0, 3), "trap4");
      t = mk(0, 0, 0, 2'b00, 32'h0, 32'h84, 0, 0, 3); t.trap = 1;
      step(t, "trap5");
      step(mk(1, 0, 0, 2'b01, 32'h40, 32'h84, 0, 0, 3), "trap6");
      // Trap and halt together: trap taken, then halted
      do_reset();
      step(mk(1, 0, 0, 2'b00, 32'h0, 32'h0, 0, 1, 0), "trh0");
      t = mk(0, 1, 0, 2'b00, 32'h0, 32'h80, 1, 0, 1); t.trap = 1;
      step(t, "trh1");
      step(mk(0, 0, 0, 2'b00, 32'h0, 32'h80, 0, 0, 1), "trh2");
`else
      t = mk(0, 0, 0, 2'b00, 32'h0, 32'h0, 0, 0, 0);
      if (t.trap) $display("unused trap field set");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
